// File: rtl/line_pixel_plotter_pkg.sv
// Shared definitions for the rasteriser back end: plotter FSM encodings,
// framebuffer geometry defaults and a saturating counter helper.
package line_pixel_plotter_pkg;

    // Default framebuffer geometry, shared with the line and triangle rasterisers.
    localparam int FB_W_DEF    = 64;
    localparam int FB_H_DEF    = 48;
    localparam int ADDR_W_DEF  = 12;
    localparam int COLOR_W_DEF = 8;

    // Plotter FSM. The encoding is fixed so that debug checkers and the
    // rasterisers can decode the 2-bit state directly.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } plot_state_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/line_pixel_plotter_pix_fifo.sv
// Small synchronous FIFO that holds framebuffer addresses while the
// framebuffer write port is stalled. Reset shares the plotter's start line.
module pix_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         start,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Guard the strobes so a misbehaving caller cannot corrupt the pointers.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage array: no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; start discards everything queued.
    always_ff @(posedge clk) begin
        if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_pixel_plotter.sv
// Consumer end of the line generator's pixel stream. Clips points to the
// framebuffer, drops consecutive duplicates, converts survivors to linear
// addresses and writes them out through a stall-absorbing FIFO.
module line_pixel_plotter
    import line_pixel_plotter_pkg::*;
#(
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int DEDUP   = 1
) (
    input  logic               clk,
    input  logic               start,
    input  logic               px_valid,
    input  logic signed [31:0] px_x,
    input  logic signed [31:0] px_y,
    output logic               px_ready,
    input  logic               src_finish,
    input  logic [COLOR_W-1:0] color,
    input  logic               fb_stall,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic [15:0]        plotted,
    output logic [15:0]        clipped,
    output logic               done
);

    // Handshake: a point transfers on a rising edge where px_valid and
    // px_ready are both high. px_ready never depends on px_valid; the source
    // must hold px_x/px_y stable while px_valid is high and not yet accepted.
    // On the write side fb_we is a strobe, not a handshake: the plotter only
    // raises it when fb_stall is low, so every fb_we cycle is a completed write.

    localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

    plot_state_t        state;
    plot_state_t        state_nxt;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0]  hist_addr;
    logic               hist_valid;
    logic [15:0]        plotted_q;
    logic [15:0]        clipped_q;

    logic               hs;
    logic               pt_out;
    logic               pt_dup;
    logic [ADDR_W-1:0]  x_in;
    logic [ADDR_W-1:0]  y_in;
    logic [ADDR_W-1:0]  pt_addr;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADDR_W-1:0]  fifo_head;

    // Signed 32-bit bounds check; anything outside the framebuffer is clipped.
    assign pt_out = (px_x < 0) | (px_x >= FB_W) | (px_y < 0) | (px_y >= FB_H);

    // The multiply only matters for in-bounds points, where x and y fit in
    // ADDR_W bits and y*FB_W + x < 2**ADDR_W, so the low slices are exact.
    assign x_in    = px_x[ADDR_W-1:0];
    assign y_in    = px_y[ADDR_W-1:0];
    assign pt_addr = y_in * FB_W_A + x_in;

    // For in-bounds points the linear address is a one-to-one map of (x,y),
    // so history stores the address and compares that.
    assign pt_dup = (DEDUP != 0) && hist_valid && (hist_addr == pt_addr);

    // Next state, handshake and write strobe; start masks both strobes so
    // nothing transfers in the cycle the block is being reset.
    always_comb begin
        state_nxt = state;
        px_ready  = 1'b0;
        fb_we     = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Conservative: a full FIFO refuses points even if it pops now.
                px_ready = ~fifo_full;
                if (src_finish) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !fb_we) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (state != S_IDLE) begin
            fb_we = ~fifo_empty & ~fb_stall;
        end
        if (start) begin
            px_ready = 1'b0;
            fb_we    = 1'b0;
        end
    end

    assign hs        = px_valid & px_ready;
    assign fifo_push = hs & ~pt_out & ~pt_dup;
    assign fifo_pop  = fb_we;

    // Hold the address at zero while nothing is queued so the bus is quiet.
    assign fb_addr = fifo_empty ? '0 : fifo_head;
    assign fb_data = color_q;
    assign plotted = plotted_q;
    assign clipped = clipped_q;
    assign done    = (state == S_DONE);

    // FSM state register; start always returns to IDLE.
    always_ff @(posedge clk) begin
        if (start) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Colour is captured once per line, on the IDLE cycle after start falls.
    always_ff @(posedge clk) begin
        if (start) begin
            color_q <= '0;
        end else if (state == S_IDLE) begin
            color_q <= color;
        end
    end

    // Duplicate history tracks the last point actually queued.
    always_ff @(posedge clk) begin
        if (start) begin
            hist_valid <= 1'b0;
            hist_addr  <= '0;
        end else if (fifo_push) begin
            hist_valid <= 1'b1;
            hist_addr  <= pt_addr;
        end
    end

    // Saturating statistics: pixels written and points clipped.
    always_ff @(posedge clk) begin
        if (start) begin
            plotted_q <= '0;
            clipped_q <= '0;
        end else begin
            if (fb_we) begin
                plotted_q <= sat_inc16(plotted_q);
            end
            if (hs && pt_out) begin
                clipped_q <= sat_inc16(clipped_q);
            end
        end
    end

    pix_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .start (start),
        .push  (fifo_push),
        .din   (pt_addr),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_line_pixel_plotter.sv
// Directed bench for line_pixel_plotter: one task per scenario, expected
// write addresses built from hand-computed values in exp_q.
module tb_line_pixel_plotter;
    import line_pixel_plotter_pkg::*;

    localparam int ADDR_W  = 12;
    localparam int COLOR_W = 8;

    logic               clk = 1'b0;
    logic               start;
    logic               px_valid;
    logic signed [31:0] px_x;
    logic signed [31:0] px_y;
    logic               px_ready;
    logic               src_finish;
    logic [COLOR_W-1:0] color;
    logic               fb_stall;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic [15:0]        plotted;
    logic [15:0]        clipped;
    logic               done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [ADDR_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0]  got_q[$];
    logic [COLOR_W-1:0] got_d[$];
    int                 got_cyc[$];

    line_pixel_plotter dut (
        .clk        (clk),
        .start      (start),
        .px_valid   (px_valid),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_ready   (px_ready),
        .src_finish (src_finish),
        .color      (color),
        .fb_stall   (fb_stall),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .plotted    (plotted),
        .clipped    (clipped),
        .done       (done)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: record every framebuffer write mid-cycle
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            got_q.push_back(fb_addr);
            got_d.push_back(fb_data);
            got_cyc.push_back(cyc);
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_d.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input logic [COLOR_W-1:0] c);
        start      = 1'b1;
        px_valid   = 1'b0;
        src_finish = 1'b0;
        color      = c;
        tick();
        tick();
        start = 1'b0;
        clear_logs();
    endtask

    // Offer one point until accepted; src_finish is raised only in the
    // cycle the point is known to be accepted.
    task automatic send_point(input int x, input int y, input bit fin, output bit ok);
        bit rdy;
        ok         = 1'b0;
        px_valid   = 1'b1;
        px_x       = x;
        px_y       = y;
        src_finish = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rdy = px_ready;
            if (rdy) src_finish = fin;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        px_valid   = 1'b0;
        src_finish = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (px_ready !== 1'b0) begin n_bad++; $display("FAIL reset_px_ready: got %b expected 0", px_ready); end
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we: got %b expected 0", fb_we); end
        n_cmp++; if (fb_addr !== 12'd0) begin n_bad++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        n_cmp++; if (fb_data !== 8'd0) begin n_bad++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
        n_cmp++; if (plotted !== 16'd0) begin n_bad++; $display("FAIL reset_plotted: got %0d expected 0", plotted); end
        n_cmp++; if (clipped !== 16'd0) begin n_bad++; $display("FAIL reset_clipped: got %0d expected 0", clipped); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (dut.state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dut.state, S_IDLE); end
        start = 1'b0;
    endtask

    task automatic test_diagonal();
        bit ok;
        bit seen;
        int at;
        int n_acc;
        n_acc = 0;
        do_reset(8'hA5);
        tick();
        color = 8'h3C;    // colour was already latched; this must not reach fb_data
        for (int i = 1; i <= 20; i++) begin
            send_point(i, i + 1, (i == 20), ok);
            if (ok) n_acc++;
            exp_q.push_back(ADDR_W'((i + 1) * 64 + i));
        end
        wait_done(seen, at);
        n_cmp++; if (n_acc !== 20) begin n_bad++; $display("FAIL diag_accepts: got %0d expected 20", n_acc); end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL diag_done_timeout: got %b expected 1", seen); end
        n_cmp++; if (got_q.size() !== 20) begin n_bad++; $display("FAIL diag_write_count: got %0d expected 20", got_q.size()); end
        if (got_q.size() == 20) begin
            n_cmp++; if (got_q[0] !== 12'd129) begin n_bad++; $display("FAIL diag_first_addr: got %0d expected 129", got_q[0]); end
            n_cmp++; if (got_q[19] !== 12'd1364) begin n_bad++; $display("FAIL diag_last_addr: got %0d expected 1364", got_q[19]); end
            for (int k = 0; k < 20; k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL diag_addr[%0d]: got %0d expected %0d", k, got_q[k], exp_q[k]); end
            end
            n_cmp++; if (got_d[0] !== 8'hA5) begin n_bad++; $display("FAIL diag_data: got %h expected a5", got_d[0]); end
            n_cmp++; if (at - got_cyc[19] !== 2) begin n_bad++; $display("FAIL diag_done_latency: got %0d expected 2", at - got_cyc[19]); end
        end
        n_cmp++; if (plotted !== 16'd20) begin n_bad++; $display("FAIL diag_plotted: got %0d expected 20", plotted); end
        n_cmp++; if (clipped !== 16'd0) begin n_bad++; $display("FAIL diag_clipped: got %0d expected 0", clipped); end
    endtask

    task automatic test_clip();
        bit ok;
        bit seen;
        int at;
        do_reset(8'h11);
        send_point(-1, 0, 1'b0, ok);
        send_point(64, 0, 1'b0, ok);
        send_point(0, 48, 1'b0, ok);
        send_point(63, 47, 1'b1, ok);
        wait_done(seen, at);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL clip_done_timeout: got %b expected 1", seen); end
        n_cmp++; if (clipped !== 16'd3) begin n_bad++; $display("FAIL clip_clipped: got %0d expected 3", clipped); end
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL clip_write_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== 12'd3071) begin n_bad++; $display("FAIL clip_addr: got %0d expected 3071", got_q[0]); end
        end
        n_cmp++; if (plotted !== 16'd1) begin n_bad++; $display("FAIL clip_plotted: got %0d expected 1", plotted); end
    endtask

    task automatic test_dedup();
        bit ok;
        bit seen;
        int at;
        do_reset(8'h22);
        send_point(5, 5, 1'b0, ok);
        send_point(5, 5, 1'b0, ok);
        send_point(6, 5, 1'b0, ok);
        send_point(5, 5, 1'b1, ok);
        exp_q.push_back(12'd325);
        exp_q.push_back(12'd326);
        exp_q.push_back(12'd325);
        wait_done(seen, at);
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL dedup_done_timeout: got %b expected 1", seen); end
        n_cmp++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL dedup_write_count: got %0d expected 3", got_q.size()); end
        if (got_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL dedup_addr[%0d]: got %0d expected %0d", k, got_q[k], exp_q[k]); end
            end
        end
        n_cmp++; if (plotted !== 16'd3) begin n_bad++; $display("FAIL dedup_plotted: got %0d expected 3", plotted); end
        n_cmp++; if (clipped !== 16'd0) begin n_bad++; $display("FAIL dedup_clipped: got %0d expected 0", clipped); end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        int at;
        int n_acc;
        logic ready_after4;
        int writes_in_stall;
        n_acc           = 0;
        ready_after4    = 1'bx;
        writes_in_stall = -1;
        fb_stall = 1'b1;
        do_reset(8'h33);
        tick();
        for (int i = 0; i < 6; i++) exp_q.push_back(ADDR_W'(74 + i));
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send_point(10 + i, 1, 1'b0, ok);
                    if (ok) n_acc++;
                end
                @(negedge clk);
                ready_after4    = px_ready;
                writes_in_stall = got_q.size();
                send_point(14, 1, 1'b0, ok);
                if (ok) n_acc++;
                send_point(15, 1, 1'b1, ok);
                if (ok) n_acc++;
            end
            begin
                repeat (10) tick();
                fb_stall = 1'b0;
            end
        join
        wait_done(seen, at);
        n_cmp++; if (ready_after4 !== 1'b0) begin n_bad++; $display("FAIL stall_ready_full: got %b expected 0", ready_after4); end
        n_cmp++; if (writes_in_stall !== 0) begin n_bad++; $display("FAIL stall_writes_while_stalled: got %0d expected 0", writes_in_stall); end
        n_cmp++; if (n_acc !== 6) begin n_bad++; $display("FAIL stall_accepts: got %0d expected 6", n_acc); end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL stall_done_timeout: got %b expected 1", seen); end
        n_cmp++; if (got_q.size() !== 6) begin n_bad++; $display("FAIL stall_write_count: got %0d expected 6", got_q.size()); end
        if (got_q.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", k, got_q[k], exp_q[k]); end
            end
        end
        n_cmp++; if (plotted !== 16'd6) begin n_bad++; $display("FAIL stall_plotted: got %0d expected 6", plotted); end
    endtask

    task automatic test_finish_empty();
        do_reset(8'h44);
        tick();
        tick();
        src_finish = 1'b1;
        tick();
        src_finish = 1'b0;
        @(negedge clk);
        n_cmp++; if (dut.state !== S_DRAIN) begin n_bad++; $display("FAIL fin_state_drain: got %0d expected %0d", dut.state, S_DRAIN); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL fin_done_early: got %b expected 0", done); end
        tick();
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fin_done: got %b expected 1", done); end
        n_cmp++; if (dut.state !== S_DONE) begin n_bad++; $display("FAIL fin_state_done: got %0d expected %0d", dut.state, S_DONE); end
        n_cmp++; if (plotted !== 16'd0) begin n_bad++; $display("FAIL fin_plotted: got %0d expected 0", plotted); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL fin_writes: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_reset_in_drain();
        bit ok;
        fb_stall = 1'b1;
        do_reset(8'h55);
        tick();
        send_point(1, 1, 1'b0, ok);
        send_point(2, 1, 1'b0, ok);
        send_point(3, 1, 1'b1, ok);
        @(negedge clk);
        n_cmp++; if (dut.state !== S_DRAIN) begin n_bad++; $display("FAIL rdrain_state: got %0d expected %0d", dut.state, S_DRAIN); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rdrain_pre_writes: got %0d expected 0", got_q.size()); end
        start = 1'b1;
        tick();
        start    = 1'b0;
        fb_stall = 1'b0;
        @(negedge clk);
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL rdrain_fb_we: got %b expected 0", fb_we); end
        n_cmp++; if (plotted !== 16'd0) begin n_bad++; $display("FAIL rdrain_plotted: got %0d expected 0", plotted); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rdrain_done: got %b expected 0", done); end
        n_cmp++; if (dut.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rdrain_fifo_empty: got %b expected 1", dut.fifo_empty); end
        n_cmp++; if (fb_addr !== 12'd0) begin n_bad++; $display("FAIL rdrain_fb_addr: got %0d expected 0", fb_addr); end
        repeat (8) tick();
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rdrain_post_writes: got %0d expected 0", got_q.size()); end
        n_cmp++; if (plotted !== 16'd0) begin n_bad++; $display("FAIL rdrain_post_plotted: got %0d expected 0", plotted); end
    endtask

    // Main sequence
    initial begin
        start      = 1'b1;
        px_valid   = 1'b0;
        px_x       = '0;
        px_y       = '0;
        src_finish = 1'b0;
        color      = '0;
        fb_stall   = 1'b0;
        test_reset();
        test_diagonal();
        test_clip();
        test_dedup();
        test_stall();
        test_finish_empty();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
